// File: rtl/adc_spi_config_seq.sv
// ADC 3-wire SPI configuration sequencer: power-up wait, fixed init table,
// then single-register write requests; also owns the ADC output enable.
module adc_spi_config_seq #(
    parameter int unsigned CLK_DIV      = 4,
    parameter int unsigned PWRUP_CYCLES = 1000,
    parameter int unsigned GAP_CYCLES   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [12:0] req_addr,
    input  logic [7:0]  req_data,
    output logic        req_ready,
    output logic        adc_csbn,
    output logic        adc_sclk,
    output logic        adc_sdio,
    output logic        adc_oen,
    output logic        init_done,
    output logic        busy,
    output logic [7:0]  frame_count
);

    localparam int unsigned SLOT_CYCLES = 2 * CLK_DIV;
    localparam int unsigned CNT_MAX_A   = (PWRUP_CYCLES > GAP_CYCLES) ? PWRUP_CYCLES : GAP_CYCLES;
    localparam int unsigned CNT_MAX     = (CNT_MAX_A > SLOT_CYCLES) ? CNT_MAX_A : SLOT_CYCLES;
    localparam int unsigned CNT_W       = $clog2(CNT_MAX + 1);
    localparam int unsigned WORD_W      = 24;
    localparam int unsigned REQ_W       = 21;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_LOAD,
        ST_SHIFT,
        ST_GAP,
        ST_IDLE
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [4:0]          bit_cnt_q, bit_cnt_d;
    logic [WORD_W-2:0]   sh_q, sh_d;
    logic [1:0]          idx_q, idx_d;
    logic [REQ_W-1:0]    req_word_q, req_word_d;
    logic                csbn_q, csbn_d;
    logic                sclk_q, sclk_d;
    logic                sdio_q, sdio_d;
    logic                oen_q, oen_d;
    logic                init_done_q, init_done_d;
    logic                busy_q, busy_d;
    logic                req_ready_q, req_ready_d;
    logic [7:0]          frame_count_q, frame_count_d;
    logic [WORD_W-1:0]   load_word;

    // Write frame: R/W=0, byte-count=00, 13-bit address, 8-bit data
    function automatic logic [WORD_W-1:0] init_word(input logic [1:0] idx);
        logic [WORD_W-1:0] w;
        case (idx)
            2'd0:    w = {3'b000, 13'h000, 8'h3C};
            2'd1:    w = {3'b000, 13'h014, 8'h00};
            2'd2:    w = {3'b000, 13'h00D, 8'h00};
            default: w = {3'b000, 13'h0FF, 8'h01};
        endcase
        return w;
    endfunction

    assign load_word = init_done_q ? {3'b000, req_word_q} : init_word(idx_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_PWRUP;
            cnt_q         <= '0;
            bit_cnt_q     <= '0;
            sh_q          <= '0;
            idx_q         <= '0;
            req_word_q    <= '0;
            csbn_q        <= 1'b1;
            sclk_q        <= 1'b0;
            sdio_q        <= 1'b0;
            oen_q         <= 1'b1;
            init_done_q   <= 1'b0;
            busy_q        <= 1'b1;
            req_ready_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            sh_q          <= sh_d;
            idx_q         <= idx_d;
            req_word_q    <= req_word_d;
            csbn_q        <= csbn_d;
            sclk_q        <= sclk_d;
            sdio_q        <= sdio_d;
            oen_q         <= oen_d;
            init_done_q   <= init_done_d;
            busy_q        <= busy_d;
            req_ready_q   <= req_ready_d;
            frame_count_q <= frame_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_cnt_d     = bit_cnt_q;
        sh_d          = sh_q;
        idx_d         = idx_q;
        req_word_d    = req_word_q;
        csbn_d        = 1'b1;
        sclk_d        = 1'b0;
        sdio_d        = 1'b0;
        oen_d         = oen_q;
        init_done_d   = init_done_q;
        frame_count_d = frame_count_q;

        case (state_q)
            ST_PWRUP: begin
                if (cnt_q == CNT_W'(PWRUP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_LOAD: begin
                // Bit 23 goes out together with the csbn fall
                state_d   = ST_SHIFT;
                cnt_d     = '0;
                bit_cnt_d = 5'd23;
                csbn_d    = 1'b0;
                sdio_d    = load_word[WORD_W-1];
                sh_d      = load_word[WORD_W-2:0];
            end
            ST_SHIFT: begin
                if (cnt_q == CNT_W'(SLOT_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (bit_cnt_q == 5'd0) begin
                        state_d       = ST_GAP;
                        frame_count_d = frame_count_q + 8'd1;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 5'd1;
                        csbn_d    = 1'b0;
                        sdio_d    = sh_q[WORD_W-2];
                        sh_d      = {sh_q[WORD_W-3:0], 1'b0};
                    end
                end else begin
                    // sclk high for the second half of each bit slot
                    cnt_d  = cnt_q + CNT_W'(1);
                    csbn_d = 1'b0;
                    sdio_d = sdio_q;
                    sclk_d = (cnt_q >= CNT_W'(CLK_DIV - 1));
                end
            end
            ST_GAP: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (!init_done_q && (idx_q != 2'd3)) begin
                        idx_d   = idx_q + 2'd1;
                        state_d = ST_LOAD;
                    end else begin
                        init_done_d = 1'b1;
                        oen_d       = 1'b0;
                        state_d     = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (req_valid) begin
                    req_word_d = {req_addr, req_data};
                    state_d    = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_PWRUP;
                cnt_d   = '0;
            end
        endcase

        busy_d      = (state_d != ST_IDLE);
        req_ready_d = (state_d == ST_IDLE);
    end

    assign req_ready   = req_ready_q;
    assign adc_csbn    = csbn_q;
    assign adc_sclk    = sclk_q;
    assign adc_sdio    = sdio_q;
    assign adc_oen     = oen_q;
    assign init_done   = init_done_q;
    assign busy        = busy_q;
    assign frame_count = frame_count_q;

endmodule

// File: tb/tb_adc_spi_config_seq.sv
// Self-checking bench for adc_spi_config_seq: decodes SPI frames from the pins
// and compares them with hand-computed words, counts and cycle positions.
module tb_adc_spi_config_seq;

    localparam int CLK_DIV      = 2;
    localparam int PWRUP_CYCLES = 16;
    localparam int GAP_CYCLES   = 8;
    localparam int LOW_CYCLES   = 48 * CLK_DIV;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [12:0] req_addr;
    logic [7:0]  req_data;
    logic        req_ready;
    logic        adc_csbn, adc_sclk, adc_sdio, adc_oen;
    logic        init_done, busy;
    logic [7:0]  frame_count;

    adc_spi_config_seq #(
        .CLK_DIV      (CLK_DIV),
        .PWRUP_CYCLES (PWRUP_CYCLES),
        .GAP_CYCLES   (GAP_CYCLES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .adc_csbn    (adc_csbn),
        .adc_sclk    (adc_sclk),
        .adc_sdio    (adc_sdio),
        .adc_oen     (adc_oen),
        .init_done   (init_done),
        .busy        (busy),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [12:0] addr;
        logic [7:0]  data;
        logic [23:0] exp_word;
        logic [7:0]  exp_fc;
    } vec_t;

    int tests = 0;
    int fails = 0;

    // Clock edges since reset release
    int cyc;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int hs_q[$];
    always @(posedge clk or posedge reset) begin
        if (reset) hs_q.delete();
        else if (req_valid && req_ready) hs_q.push_back(cyc);
    end

    // Pin-level frame decoder
    logic [23:0] word_q[$];
    int          fc_q[$];
    int          fall_q[$];
    logic [23:0] shreg;
    bit          in_frame, have_prev, prev_sclk, prev_sdio, prev_init, wrap_seen;
    int          rises, low_cnt, high_cnt, min_gap, init_cyc, prev_fc;
    int          bad_frames = 0, sdio_viol = 0, sclk_idle_viol = 0, ready_early = 0, revert = 0;

    always @(negedge clk) begin
        if (reset) begin
            word_q.delete(); fc_q.delete(); fall_q.delete();
            in_frame = 0; have_prev = 0; prev_sclk = 0; prev_sdio = 0; prev_init = 0;
            rises = 0; low_cnt = 0; high_cnt = 0; min_gap = 1000000; init_cyc = -1; prev_fc = 0;
            shreg = '0;
        end else begin
            if (!adc_csbn) begin
                if (!in_frame) begin
                    in_frame = 1; low_cnt = 0; rises = 0; shreg = '0;
                    fall_q.push_back(cyc);
                    if (have_prev && high_cnt < min_gap) min_gap = high_cnt;
                end
                low_cnt++;
                if (adc_sclk && !prev_sclk) begin
                    shreg = {shreg[22:0], adc_sdio};
                    rises++;
                end
                if (adc_sclk && (adc_sdio != prev_sdio)) sdio_viol++;
            end else begin
                if (in_frame) begin
                    in_frame = 0; have_prev = 1; high_cnt = 0;
                    word_q.push_back(shreg);
                    fc_q.push_back(int'(frame_count));
                    if (low_cnt != LOW_CYCLES || rises != 24) bad_frames++;
                end
                high_cnt++;
                if (adc_sclk) sclk_idle_viol++;
            end
            if (req_ready && !init_done) ready_early++;
            if (prev_init && !init_done) revert++;
            if (init_done && init_cyc < 0) init_cyc = cyc;
            if (prev_fc == 255 && frame_count == 8'd0) wrap_seen = 1;
            prev_sclk = adc_sclk; prev_sdio = adc_sdio;
            prev_init = init_done; prev_fc = int'(frame_count);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_frames(input int n, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            if (word_q.size() >= n) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            if (req_ready) begin
                ok = 1;
                break;
            end
            tick();
        end
    endtask

    task automatic do_req(input vec_t v, input int idx);
        bit ok;
        int n, h;
        wait_ready(ok);
        check($sformatf("vec%0d_ready_timeout", idx), 32'(ok), 1);
        check($sformatf("vec%0d_busy_idle", idx), 32'(busy), 0);
        n = word_q.size();
        h = hs_q.size();
        req_addr  = v.addr;
        req_data  = v.data;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check($sformatf("vec%0d_ready_drop", idx), 32'(req_ready), 0);
        check($sformatf("vec%0d_busy_frame", idx), 32'(busy), 1);
        wait_frames(n + 1, 400, ok);
        check($sformatf("vec%0d_frame_timeout", idx), 32'(ok), 1);
        if (ok && hs_q.size() > h) begin
            check($sformatf("vec%0d_word", idx), 32'(word_q[n]), 32'(v.exp_word));
            check($sformatf("vec%0d_fc", idx), 32'(fc_q[n]), 32'(v.exp_fc));
            check($sformatf("vec%0d_latency", idx), 32'(fall_q[n] - hs_q[h]), 2);
        end
    endtask

    vec_t init_vecs[4];
    vec_t vecs[5];

    initial begin
        bit ok;
        int n0, h0;

        init_vecs[0] = '{13'h000, 8'h3C, 24'h00003C, 8'd1};
        init_vecs[1] = '{13'h014, 8'h00, 24'h001400, 8'd2};
        init_vecs[2] = '{13'h00D, 8'h00, 24'h000D00, 8'd3};
        init_vecs[3] = '{13'h0FF, 8'h01, 24'h00FF01, 8'd4};
        vecs[0] = '{13'h018,  8'hA5, 24'h0018A5, 8'd6};
        vecs[1] = '{13'h1FFF, 8'hFF, 24'h1FFFFF, 8'd7};
        vecs[2] = '{13'h000,  8'h00, 24'h000000, 8'd8};
        vecs[3] = '{13'h0AA,  8'h55, 24'h00AA55, 8'd9};
        vecs[4] = '{13'h1555, 8'h81, 24'h155581, 8'd10};

        // Request held from reset onwards
        reset = 1'b1; req_valid = 1'b1; req_addr = 13'h123; req_data = 8'h5A;
        tick(); tick();
        check("rst_csbn", 32'(adc_csbn), 1);
        check("rst_sclk", 32'(adc_sclk), 0);
        check("rst_sdio", 32'(adc_sdio), 0);
        check("rst_oen", 32'(adc_oen), 1);
        check("rst_ready", 32'(req_ready), 0);
        check("rst_init_done", 32'(init_done), 0);
        check("rst_busy", 32'(busy), 1);
        check("rst_fc", 32'(frame_count), 0);

        // Reset in the middle of bit 10 of the second init frame
        reset = 1'b0;
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (word_q.size() == 1 && in_frame && rises == 13) begin
                ok = 1;
                break;
            end
        end
        check("reach_frame2_bit10", 32'(ok), 1);
        tick(); tick(); tick();
        check("pre_reset_fc", 32'(frame_count), 1);
        check("pre_reset_csbn", 32'(adc_csbn), 0);
        reset = 1'b1;
        #1;
        check("midrst_csbn", 32'(adc_csbn), 1);
        check("midrst_sclk", 32'(adc_sclk), 0);
        check("midrst_init_done", 32'(init_done), 0);
        check("midrst_fc", 32'(frame_count), 0);
        check("midrst_busy", 32'(busy), 1);
        tick(); tick();
        reset = 1'b0;

        // Full init, then the held request is taken as frame 5
        ok = 0;
        for (int i = 0; i < 1000; i++) begin
            if (hs_q.size() >= 1) begin
                ok = 1;
                break;
            end
            tick();
        end
        check("held_hs_timeout", 32'(ok), 1);
        check("held_ready_drop", 32'(req_ready), 0);
        req_valid = 1'b0;
        wait_frames(5, 500, ok);
        check("init_frames_timeout", 32'(ok), 1);
        if (ok) begin
            check("first_fall_cycle", 32'(fall_q[0]), 32'(PWRUP_CYCLES + 1));
            for (int i = 0; i < 4; i++) begin
                check($sformatf("init_word%0d", i), 32'(word_q[i]), 32'(init_vecs[i].exp_word));
                check($sformatf("init_fc%0d", i), 32'(fc_q[i]), 32'(init_vecs[i].exp_fc));
                if (i > 0)
                    check($sformatf("init_period%0d", i), 32'(fall_q[i] - fall_q[i-1]),
                          32'(LOW_CYCLES + GAP_CYCLES + 1));
            end
            check("init_done_cycle", 32'(init_cyc), 436);
            check("held_hs_cycle", 32'(hs_q[0]), 436);
            check("held_word", 32'(word_q[4]), 32'h01235A);
            check("held_fc", 32'(fc_q[4]), 5);
            check("held_latency", 32'(fall_q[4] - hs_q[0]), 2);
        end
        check("oen_after_init", 32'(adc_oen), 0);
        check("ready_before_init", 32'(ready_early), 0);

        for (int i = 0; i < 5; i++) do_req(vecs[i], i);

        // Back-to-back requests with req_valid held
        wait_ready(ok);
        check("b2b_ready_timeout", 32'(ok), 1);
        n0 = word_q.size();
        h0 = hs_q.size();
        req_addr = 13'h033; req_data = 8'h3C; req_valid = 1'b1;
        wait_frames(n0 + 3, 500, ok);
        req_valid = 1'b0;
        check("b2b_timeout", 32'(ok), 1);
        for (int i = 0; i < 20; i++) tick();
        check("b2b_handshakes", 32'(hs_q.size() - h0), 3);
        check("b2b_frames", 32'(word_q.size() - n0), 3);
        if (ok) begin
            check("b2b_word", 32'(word_q[n0 + 2]), 32'h00333C);
            check("b2b_period", 32'(fall_q[n0 + 1] - fall_q[n0]), 32'(LOW_CYCLES + GAP_CYCLES + 2));
        end
        check("min_gap_ok", 32'(min_gap >= GAP_CYCLES), 1);
        check("b2b_fc", 32'(frame_count), 13);

        // 256 more frames: frame_count wraps back to the same value
        wait_ready(ok);
        check("wrap_ready_timeout", 32'(ok), 1);
        n0 = word_q.size();
        h0 = hs_q.size();
        req_addr = 13'h0A0; req_data = 8'hC3; req_valid = 1'b1;
        wait_frames(n0 + 256, 256 * 120, ok);
        req_valid = 1'b0;
        check("wrap_timeout", 32'(ok), 1);
        for (int i = 0; i < 20; i++) tick();
        check("wrap_handshakes", 32'(hs_q.size() - h0), 256);
        check("wrap_fc", 32'(frame_count), 13);
        check("wrap_seen", 32'(wrap_seen), 1);
        check("wrap_last_word", 32'(word_q[word_q.size() - 1]), 32'h00A0C3);

        check("bad_frames", 32'(bad_frames), 0);
        check("sdio_changes_sclk_high", 32'(sdio_viol), 0);
        check("sclk_idle_high", 32'(sclk_idle_viol), 0);
        check("init_done_revert", 32'(revert), 0);
        check("final_init_done", 32'(init_done), 1);
        check("final_ready", 32'(req_ready), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
